mul_issue_scheduler: RTL and testbench
======================================

// Module: mul_issue_scheduler
// PURPOSE
//  Shares the single iterative Booth multiply unit between NUM_REQ reservation-station ports.
//  Picks one ready request by round-robin and launches it into the unit.
//  Tracks its ROB tag and mulh flag, and buffers the result until the CDB accepts it.
//  Squashes in-flight and buffered work on a pipeline flush. Sits between the mul RS entries and the CDB arbiter in Execute.
// PARAMETERS
//  NUM_REQ    4   number of requesting RS ports
//  XLEN       32  operand/result width
//  ROB_TAG_W  3   ROB entry tag width
// PORTS
//  clk           in   1                  system clock, all state on posedge
//  reset         in   1                  asynchronous, active-low reset
//  req_valid     in   NUM_REQ            RS port i holds a ready mul op
//  req_a         in   NUM_REQ*XLEN       multiplier operand, port i at [i*XLEN +: XLEN]
//  req_b         in   NUM_REQ*XLEN       multiplicand operand, same packing
//  req_mulh      in   NUM_REQ            1 = high half wanted
//  req_tag       in   NUM_REQ*ROB_TAG_W  ROB tag per port
//  req_grant     out  NUM_REQ            one-hot; port i's op accepted this cycle
//  fu_valid_in   out  1                  launch to multiply unit
//  fu_multiplier out  XLEN               muxed req_a of granted port
//  fu_multiplicand out XLEN              muxed req_b of granted port
//  fu_mulh       out  1                  registered mulh of in-flight op
//  fu_rob_tag    out  ROB_TAG_W          muxed tag of granted port
//  fu_ready      in   1                  unit idle
//  fu_valid_out  in   1                  unit result valid
//  fu_result     in   64                 unit result; low XLEN bits used
//  fu_yumi       out  1                  result consumed by scheduler
//  flush         in   1                  squash all mul work
//  cdb_req       out  1                  buffered result awaiting broadcast
//  cdb_tag       out  ROB_TAG_W          tag of buffered result
//  cdb_data      out  XLEN               buffered result
//  cdb_grant     in   1                  CDB accepts buffered result this cycle
// BEHAVIOUR
//  - Reset (reset=0, async): inflight_v=0, squash=0, wb_v=0, rr_ptr=0, mulh_q=0.
//    All outputs 0: req_grant, fu_valid_in, fu_yumi, cdb_req, cdb_tag, cdb_data, fu_mulh.
//  - Issue condition: fu_ready & !inflight_v & !flush & |req_valid.
//    In that cycle, combinationally: req_grant = one-hot RR pick starting at rr_ptr; fu_valid_in=1.
//    fu_multiplier, fu_multiplicand and fu_rob_tag are muxed from the granted port.
//    Next edge: inflight_v<=1, tag_q<=tag, mulh_q<=mulh, rr_ptr<=grant_idx+1 (wraps at NUM_REQ).
//  - fu_valid_in is a single-cycle pulse; never asserted while inflight_v=1.
//  - fu_mulh = mulh_q, held stable from issue until fu_yumi, because the unit selects the half combinationally.
//  - Issue is allowed while wb_v=1: the buffer and the unit are independent slots.
//  - Capture: fu_yumi = inflight_v & fu_valid_out & (squash | !wb_v | cdb_grant).
//    On fu_yumi & !squash: wb_v<=1, data_q<=fu_result[XLEN-1:0], wb_tag<=tag_q.
//    On any fu_yumi: inflight_v<=0, squash<=0.
//    If the buffer is full and not granted, fu_yumi stays 0 and the unit holds its done state (backpressure).
//  - CDB: cdb_req=wb_v, cdb_tag=wb_tag, cdb_data=data_q. cdb_grant & !capture -> wb_v<=0.
//    cdb_grant and capture in the same cycle -> buffer reloads, wb_v stays 1.
//  - Flush: wb_v<=0 (cdb_req drops next cycle, a same-cycle cdb_grant is ignored); no grant that cycle.
//    If inflight_v, squash<=1: the op runs to completion and is yumi'd and discarded, with no CDB broadcast.
//    Flush on the same cycle as capture: the result is discarded.
//  - Latency: issue -> fu_valid_out is unit-defined (~65 cycles). Capture -> cdb_req is 1 cycle.
//  - Wait states (grant-starved) count only while the unit is busy; the RR guarantees each port a grant within NUM_REQ issues.
//  - Reset asserted mid-operation clears the scheduler only; the unit's own reset is driven from the same net.
// STRUCTURE
//  - Package mul_sched_pkg holds XLEN, ROB_TAG_W, NUM_REQ defaults and the cdb_pkt_t struct {tag, data}.
//  - Sub-module rr_arbiter #(N): inputs req, ptr; outputs one-hot gnt and gnt_idx. Purely combinational.
//  - Top holds the inflight/squash/wb registers, the operand mux and the RR pointer; fewer than 250 lines.
// TESTING
//  1. Single op: port 0 a=7, b=-6, mulh=0, tag=5.
//     -> grant=0001, fu_valid_in one cycle; cdb_req with tag=5, data=-42 (0xFFFFFFD6); cdb_grant -> cdb_req=0.
//  2. RR fairness: all 4 ports valid continuously, instant cdb_grant.
//     -> grant sequence 0001, 0010, 0100, 1000, 0001; no port skipped.
//  3. Backpressure: two ops back-to-back, cdb_grant held 0.
//     -> 2nd result: fu_valid_out=1 but fu_yumi=0 until cdb_grant.
//     -> then fu_yumi, cdb_grant and reload occur in one cycle; data becomes 2nd product.
//  4. mulh: port 2 a=0x80000000, b=2, mulh=1.
//     -> cdb_data=0xFFFFFFFF; fu_mulh stable 1 for the whole operation.
//  5. Flush mid-op at cycle 20 after issue, with a buffered result pending.
//     -> cdb_req drops next cycle; the in-flight op is yumi'd with no cdb_req.
//     -> a new request is granted once fu_ready.
//  6. Async reset (reset=0) asserted mid-op between edges.
//     -> all outputs 0 immediately; after release, the port 0 request is granted first.

Source files
------------

// File: rtl/mul_sched_pkg.sv
// Shared constants and types for the multiply issue scheduler and the
// CDB-side logic that consumes its result packets.
package mul_sched_pkg;

  localparam int NUM_REQ_DEF   = 4;
  localparam int XLEN_DEF      = 32;
  localparam int ROB_TAG_W_DEF = 3;

  // Result packet presented to the CDB arbiter.
  typedef struct packed {
    logic [ROB_TAG_W_DEF-1:0] tag;
    logic [XLEN_DEF-1:0]      data;
  } cdb_pkt_t;

  // Round-robin successor of a port index, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans req starting at ptr and grants
// the first set bit, as a one-hot vector and as an index.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  // Priority scan rotated so that port ptr has the highest priority.
  always_comb begin
    int   idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    idx     = 0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mul_issue_scheduler.sv
// Shares one iterative multiply unit between NUM_REQ reservation-station
// ports. One op is in flight at a time; its result is parked in a one-entry
// buffer until the CDB accepts it. A flush drops the buffer and marks the
// in-flight op for silent discard.
//
// Handshakes:
//   RS -> scheduler : req_valid[i] is a level; the op is taken in the cycle
//                     req_grant[i]=1 (the edge closing that cycle).
//   scheduler -> FU : fu_valid_in pulses for one cycle while fu_ready=1.
//   FU -> scheduler : fu_valid_out holds until a cycle with fu_yumi=1.
//   scheduler -> CDB: cdb_req holds until a cycle with cdb_grant=1.
module mul_issue_scheduler
  import mul_sched_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int XLEN      = XLEN_DEF,
  parameter int ROB_TAG_W = ROB_TAG_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*XLEN-1:0]      req_a,
  input  logic [NUM_REQ*XLEN-1:0]      req_b,
  input  logic [NUM_REQ-1:0]           req_mulh,
  input  logic [NUM_REQ*ROB_TAG_W-1:0] req_tag,
  output logic [NUM_REQ-1:0]           req_grant,
  output logic                         fu_valid_in,
  output logic [XLEN-1:0]              fu_multiplier,
  output logic [XLEN-1:0]              fu_multiplicand,
  output logic                         fu_mulh,
  output logic [ROB_TAG_W-1:0]         fu_rob_tag,
  input  logic                         fu_ready,
  input  logic                         fu_valid_out,
  input  logic [63:0]                  fu_result,
  output logic                         fu_yumi,
  input  logic                         flush,
  output logic                         cdb_req,
  output logic [ROB_TAG_W-1:0]         cdb_tag,
  output logic [XLEN-1:0]              cdb_data,
  input  logic                         cdb_grant
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                 inflight_v;
  logic                 squash;
  logic                 wb_v;
  logic                 mulh_q;
  logic [ROB_TAG_W-1:0] tag_q;
  logic [ROB_TAG_W-1:0] wb_tag;
  logic [XLEN-1:0]      data_q;
  logic [IDX_W-1:0]     rr_ptr;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 issue;
  logic                 capture;
  logic [ROB_TAG_W-1:0] sel_tag;
  logic                 sel_mulh;

  // Only the low XLEN bits of the unit result carry the selected half.
  logic unused_result_hi;
  assign unused_result_hi = ^fu_result[63:XLEN];

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (gnt_idx)
  );

  // Launch when the unit is idle, nothing is outstanding and no flush is
  // active; reset gating keeps every output low while reset is asserted.
  assign issue = reset & fu_ready & ~inflight_v & ~flush & (|req_valid);

  // Take the result when the buffer is free, is being drained this cycle,
  // or the result is going to be thrown away anyway.
  assign fu_yumi = reset & inflight_v & fu_valid_out & (squash | ~wb_v | cdb_grant);

  // A consumed result is kept only if neither an old nor a new flush kills it.
  assign capture = fu_yumi & ~squash & ~flush;

  assign sel_tag  = req_tag[int'(gnt_idx)*ROB_TAG_W +: ROB_TAG_W];
  assign sel_mulh = req_mulh[gnt_idx];

  // Grant and operand mux toward the unit, driven only in an issue cycle.
  always_comb begin
    req_grant       = '0;
    fu_valid_in     = 1'b0;
    fu_multiplier   = '0;
    fu_multiplicand = '0;
    fu_rob_tag      = '0;
    if (issue) begin
      req_grant       = arb_gnt;
      fu_valid_in     = 1'b1;
      fu_multiplier   = req_a[int'(gnt_idx)*XLEN +: XLEN];
      fu_multiplicand = req_b[int'(gnt_idx)*XLEN +: XLEN];
      fu_rob_tag      = sel_tag;
    end
  end

  // The unit picks the product half combinationally, so mulh is held from
  // issue through the consuming cycle.
  assign fu_mulh = mulh_q;

  assign cdb_req  = wb_v;
  assign cdb_tag  = wb_tag;
  assign cdb_data = data_q;

  // In-flight slot: tag/mulh of the launched op, squash marker, RR pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_v <= 1'b0;
      squash     <= 1'b0;
      mulh_q     <= 1'b0;
      tag_q      <= '0;
      rr_ptr     <= '0;
    end else begin
      if (issue) begin
        inflight_v <= 1'b1;
        tag_q      <= sel_tag;
        mulh_q     <= sel_mulh;
        rr_ptr     <= IDX_W'(rr_next(int'(gnt_idx), NUM_REQ));
      end
      if (fu_yumi) begin
        inflight_v <= 1'b0;
        squash     <= 1'b0;
      end else if (flush && inflight_v) begin
        squash <= 1'b1;
      end
    end
  end

  // Writeback buffer: flush wins, then reload from the unit, then drain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_v   <= 1'b0;
      wb_tag <= '0;
      data_q <= '0;
    end else begin
      if (flush) begin
        wb_v <= 1'b0;
      end else if (capture) begin
        wb_v   <= 1'b1;
        wb_tag <= tag_q;
        data_q <= fu_result[XLEN-1:0];
      end else if (cdb_grant) begin
        wb_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mul_issue_scheduler.sv
// Directed bench for mul_issue_scheduler with a behavioural multiply unit.
module tb_mul_issue_scheduler;

  localparam int NREQ = 4;
  localparam int XL   = 32;
  localparam int TW   = 3;
  localparam int LAT  = 30;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*XL-1:0] req_a;
  logic [NREQ*XL-1:0] req_b;
  logic [NREQ-1:0]    req_mulh;
  logic [NREQ*TW-1:0] req_tag;
  logic [NREQ-1:0]    req_grant;
  logic               fu_valid_in;
  logic [XL-1:0]      fu_multiplier;
  logic [XL-1:0]      fu_multiplicand;
  logic               fu_mulh;
  logic [TW-1:0]      fu_rob_tag;
  logic               fu_ready;
  logic               fu_valid_out;
  logic [63:0]        fu_result;
  logic               fu_yumi;
  logic               flush;
  logic               cdb_req;
  logic [TW-1:0]      cdb_tag;
  logic [XL-1:0]      cdb_data;
  logic               cdb_grant;

  int tests_run    = 0;
  int tests_failed = 0;

  mul_issue_scheduler dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_a           (req_a),
    .req_b           (req_b),
    .req_mulh        (req_mulh),
    .req_tag         (req_tag),
    .req_grant       (req_grant),
    .fu_valid_in     (fu_valid_in),
    .fu_multiplier   (fu_multiplier),
    .fu_multiplicand (fu_multiplicand),
    .fu_mulh         (fu_mulh),
    .fu_rob_tag      (fu_rob_tag),
    .fu_ready        (fu_ready),
    .fu_valid_out    (fu_valid_out),
    .fu_result       (fu_result),
    .fu_yumi         (fu_yumi),
    .flush           (flush),
    .cdb_req         (cdb_req),
    .cdb_tag         (cdb_tag),
    .cdb_data        (cdb_data),
    .cdb_grant       (cdb_grant)
  );

  // ---------------- multiply unit model ----------------
  // Fixed-latency signed multiplier; holds its done state until yumi and
  // selects the product half from fu_mulh combinationally.
  logic        unit_busy;
  int          unit_cnt;
  logic [63:0] prod_q;

  assign fu_ready  = ~unit_busy & ~fu_valid_out;
  assign fu_result = {32'h0, (fu_mulh ? prod_q[63:32] : prod_q[31:0])};

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      unit_busy    <= 1'b0;
      unit_cnt     <= 0;
      fu_valid_out <= 1'b0;
      prod_q       <= '0;
    end else if (fu_valid_in && fu_ready) begin
      unit_busy <= 1'b1;
      unit_cnt  <= LAT;
      prod_q    <= $signed({{32{fu_multiplier[31]}}, fu_multiplier}) *
                   $signed({{32{fu_multiplicand[31]}}, fu_multiplicand});
    end else if (unit_busy) begin
      if (unit_cnt == 1) begin
        unit_busy    <= 1'b0;
        fu_valid_out <= 1'b1;
      end
      unit_cnt <= unit_cnt - 1;
    end else if (fu_valid_out && fu_yumi) begin
      fu_valid_out <= 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_mulh  = '0;
    req_tag   = '0;
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] b,
                          input logic m, input logic [2:0] t);
    req_a[p*XL +: XL]   = a;
    req_b[p*XL +: XL]   = b;
    req_mulh[p]         = m;
    req_tag[p*TW +: TW] = t;
    req_valid[p]        = 1'b1;
  endtask

  task automatic do_reset();
    clear_reqs();
    flush     = 1'b0;
    cdb_grant = 1'b0;
    reset     = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    settle();
  endtask

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_issue(input string tag);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (fu_valid_in === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk({tag, "_issue_seen"}, ok, 1'b1);
  endtask

  task automatic wait_cdb(input string tag);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (cdb_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk({tag, "_cdb_seen"}, ok, 1'b1);
  endtask

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int viol;
    bit seen;

    clear_reqs();
    flush     = 1'b0;
    cdb_grant = 1'b0;
    reset     = 1'b0;
    #2;
    // Reset state
    chk("rst_grant", req_grant, 4'b0000);
    chk("rst_valid_in", fu_valid_in, 1'b0);
    chk("rst_yumi", fu_yumi, 1'b0);
    chk("rst_cdb_req", cdb_req, 1'b0);
    chk("rst_cdb_tag", cdb_tag, 3'd0);
    chk("rst_cdb_data", cdb_data, 32'h0);
    chk("rst_mulh", fu_mulh, 1'b0);
    do_reset();

    // 1. Single op: 7 * -6, tag 5
    set_port(0, 32'd7, 32'hFFFF_FFFA, 1'b0, 3'd5);
    settle();
    chk("t1_grant", req_grant, 4'b0001);
    chk("t1_valid_in", fu_valid_in, 1'b1);
    chk("t1_mplier", fu_multiplier, 32'd7);
    chk("t1_mcand", fu_multiplicand, 32'hFFFF_FFFA);
    chk("t1_fu_tag", fu_rob_tag, 3'd5);
    tick();
    chk("t1_pulse_valid_in", fu_valid_in, 1'b0);
    chk("t1_no_regrant", req_grant, 4'b0000);
    clear_reqs();
    wait_cdb("t1");
    chk("t1_cdb_tag", cdb_tag, 3'd5);
    chk("t1_cdb_data", cdb_data, 32'hFFFF_FFD6);
    cdb_grant = 1'b1;
    tick();
    cdb_grant = 1'b0;
    settle();
    chk("t1_cdb_drop", cdb_req, 1'b0);

    // 2. RR fairness, all ports valid, CDB always granting
    do_reset();
    for (int p = 0; p < NREQ; p++) set_port(p, 32'(p + 1), 32'd3, 1'b0, 3'(p + 1));
    cdb_grant = 1'b1;
    settle();
    wait_issue("t2a");
    chk("t2_grant0", req_grant, 4'b0001);
    chk("t2_a0", fu_multiplier, 32'd1);
    tick();
    wait_issue("t2b");
    chk("t2_grant1", req_grant, 4'b0010);
    chk("t2_a1", fu_multiplier, 32'd2);
    tick();
    wait_issue("t2c");
    chk("t2_grant2", req_grant, 4'b0100);
    chk("t2_a2", fu_multiplier, 32'd3);
    tick();
    wait_issue("t2d");
    chk("t2_grant3", req_grant, 4'b1000);
    chk("t2_a3", fu_multiplier, 32'd4);
    tick();
    wait_issue("t2e");
    chk("t2_grant4", req_grant, 4'b0001);
    tick();
    wait_cdb("t2");
    chk("t2_last_data", cdb_data, 32'd3);
    chk("t2_last_tag", cdb_tag, 3'd1);

    // 3. Backpressure with cdb_grant held low
    do_reset();
    set_port(0, 32'd3, 32'd4, 1'b0, 3'd1);
    set_port(1, 32'd5, 32'd6, 1'b0, 3'd2);
    settle();
    wait_issue("t3a");
    chk("t3_grant0", req_grant, 4'b0001);
    tick();
    req_valid[0] = 1'b0;
    settle();
    wait_cdb("t3a");
    chk("t3_first_data", cdb_data, 32'd12);
    wait_issue("t3b");
    chk("t3_grant1_while_buffered", req_grant, 4'b0010);
    tick();
    clear_reqs();
    settle();
    seen = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (fu_valid_out === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk("t3_done_seen", seen, 1'b1);
    chk("t3_yumi_blocked", fu_yumi, 1'b0);
    repeat (3) tick();
    chk("t3_yumi_still_blocked", fu_yumi, 1'b0);
    chk("t3_hold_data", cdb_data, 32'd12);
    chk("t3_hold_req", cdb_req, 1'b1);
    cdb_grant = 1'b1;
    settle();
    chk("t3_yumi_on_grant", fu_yumi, 1'b1);
    tick();
    cdb_grant = 1'b0;
    settle();
    chk("t3_reload_req", cdb_req, 1'b1);
    chk("t3_reload_data", cdb_data, 32'd30);
    chk("t3_reload_tag", cdb_tag, 3'd2);
    cdb_grant = 1'b1;
    tick();
    cdb_grant = 1'b0;
    settle();
    chk("t3_drain", cdb_req, 1'b0);

    // 4. mulh: 0x80000000 * 2 high half
    do_reset();
    set_port(2, 32'h8000_0000, 32'd2, 1'b1, 3'd3);
    settle();
    chk("t4_grant", req_grant, 4'b0100);
    tick();
    clear_reqs();
    settle();
    viol = 0;
    seen = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (cdb_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (fu_mulh !== 1'b1) viol++;
      tick();
    end
    chk("t4_cdb_seen", seen, 1'b1);
    chk("t4_mulh_stable_bad_cycles", 32'(viol), 32'd0);
    chk("t4_data", cdb_data, 32'hFFFF_FFFF);
    chk("t4_tag", cdb_tag, 3'd3);

    // 5. Flush 20 cycles after issue with a buffered result pending
    do_reset();
    set_port(0, 32'd2, 32'd2, 1'b0, 3'd1);
    settle();
    wait_issue("t5a");
    tick();
    clear_reqs();
    settle();
    wait_cdb("t5a");
    chk("t5_buffered_data", cdb_data, 32'd4);
    set_port(1, 32'd9, 32'd9, 1'b0, 3'd2);
    settle();
    wait_issue("t5b");
    chk("t5_grant1", req_grant, 4'b0010);
    tick();
    clear_reqs();
    repeat (19) tick();
    flush = 1'b1;
    set_port(3, 32'd4, 32'd5, 1'b0, 3'd6);
    settle();
    chk("t5_flush_no_grant", req_grant, 4'b0000);
    tick();
    flush = 1'b0;
    settle();
    chk("t5_cdb_drop", cdb_req, 1'b0);
    viol = 0;
    seen = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (cdb_req !== 1'b0 || req_grant !== 4'b0000) viol++;
      if (fu_yumi === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk("t5_squash_yumi_seen", seen, 1'b1);
    chk("t5_quiet_bad_cycles", 32'(viol), 32'd0);
    tick();
    chk("t5_no_broadcast", cdb_req, 1'b0);
    chk("t5_regrant", req_grant, 4'b1000);
    chk("t5_regrant_a", fu_multiplier, 32'd4);
    tick();
    clear_reqs();
    settle();
    wait_cdb("t5c");
    chk("t5_new_data", cdb_data, 32'd20);
    chk("t5_new_tag", cdb_tag, 3'd6);

    // 6. Async reset mid-op between edges
    do_reset();
    set_port(2, 32'h10, 32'h3, 1'b1, 3'd4);
    settle();
    wait_issue("t6");
    chk("t6_grant", req_grant, 4'b0100);
    tick();
    clear_reqs();
    set_port(0, 32'd1, 32'd1, 1'b0, 3'd1);
    set_port(3, 32'd2, 32'd2, 1'b0, 3'd2);
    repeat (5) tick();
    chk("t6_pre_mulh", fu_mulh, 1'b1);
    #3;
    reset = 1'b0;
    #1;
    chk("t6_rst_grant", req_grant, 4'b0000);
    chk("t6_rst_valid_in", fu_valid_in, 1'b0);
    chk("t6_rst_yumi", fu_yumi, 1'b0);
    chk("t6_rst_cdb_req", cdb_req, 1'b0);
    chk("t6_rst_mulh", fu_mulh, 1'b0);
    chk("t6_rst_cdb_data", cdb_data, 32'h0);
    tick();
    reset = 1'b1;
    settle();
    chk("t6_post_grant", req_grant, 4'b0001);
    chk("t6_post_valid_in", fu_valid_in, 1'b1);
    clear_reqs();
    tick();

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
